// File: rtl/hack_run_ctrl.sv
// hack_run_ctrl
// Run/halt/single-step controller for the HACK CPU. From one free-running
// clock it produces the CPU reset and the datapath clock enable. With it the
// CPU can be halted, single-stepped from a debounced push button, or stopped
// on a program-counter breakpoint. It also counts executed instructions for
// the display.
//
// Ports
//   i_clk         system clock (16 MHz); all state changes on its rising edge
//   i_rst_n       asynchronous active-low reset
//   i_run_req     level: 1 = free run, 0 = halt (already synchronous)
//   i_rst_req     single-cycle soft-reset request, re-enters power-on reset
//   i_step_btn    raw asynchronous active-high step button
//   i_bp_en       breakpoint enable
//   i_bp_addr     breakpoint instruction address
//   i_pc          current CPU program counter
//   o_cpu_rst     reset to the CPU
//   o_cpu_ce      CPU clock enable (combinational)
//   o_halted      1 while halted
//   o_bp_hit      sticky flag, set when the breakpoint stopped a run
//   o_insn_count  executed-instruction counter, wraps at 16 bits

module hack_run_ctrl #(
    parameter int PC_WIDTH        = 15,
    parameter int POR_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_run_req,
    input  logic                i_rst_req,
    input  logic                i_step_btn,
    input  logic                i_bp_en,
    input  logic [PC_WIDTH-1:0] i_bp_addr,
    input  logic [PC_WIDTH-1:0] i_pc,
    output logic                o_cpu_rst,
    output logic                o_cpu_ce,
    output logic                o_halted,
    output logic                o_bp_hit,
    output logic [15:0]         o_insn_count
);

    localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2,
        ST_RUN  = 2'd3
    } ctrlState_e;

    ctrlState_e        r_state;
    ctrlState_e        w_nextState;
    logic [POR_W-1:0]  r_porCnt;
    logic              r_cpuRst;
    logic              r_halted;
    logic              r_bpHit;
    logic              r_bpArmed;
    logic [15:0]       r_insnCount;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_dbLevel;
    logic              r_dbLevelQ;
    logic [DB_W-1:0]   r_dbCnt;

    logic              w_stepPulse;
    logic              w_bpMatch;
    logic              w_cpuCe;
    logic              w_setBpHit;

    // The step button is brought into the clock domain through two flops and
    // then debounced: the counter only runs while the synchronized input
    // disagrees with the accepted level, and the level flips once the
    // disagreement has lasted DEBOUNCE_CYCLES samples. Any bounce shorter
    // than that reloads the counter and is forgotten.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_dbLevel  <= 1'b0;
            r_dbLevelQ <= 1'b0;
            r_dbCnt    <= '0;
        end else begin
            r_sync1    <= i_step_btn;
            r_sync2    <= r_sync1;
            r_dbLevelQ <= r_dbLevel;
            if (r_sync2 == r_dbLevel) begin
                r_dbCnt <= '0;
            end else if (r_dbCnt == DB_LAST) begin
                r_dbLevel <= ~r_dbLevel;
                r_dbCnt   <= '0;
            end else begin
                r_dbCnt <= r_dbCnt + DB_W'(1);
            end
        end
    end

    // One pulse per accepted press (rising edge of the debounced level).
    // Only HALT listens to it, so presses seen in other states are dropped.
    assign w_stepPulse = r_dbLevel & ~r_dbLevelQ;

    // The breakpoint only counts once armed, which lets a resume that starts
    // sitting on the breakpoint address execute that instruction first.
    assign w_bpMatch = i_bp_en && r_bpArmed && (i_pc == i_bp_addr);

    // Next-state and clock-enable decode. In RUN the enable drops in the very
    // cycle a breakpoint matches or run is withdrawn, so the instruction at
    // the breakpoint is never executed before the stop. A soft-reset request
    // overrides every other transition.
    always_comb begin
        w_nextState = r_state;
        w_cpuCe     = 1'b0;
        w_setBpHit  = 1'b0;
        case (r_state)
            ST_POR: begin
                w_cpuCe = 1'b1;
                if (r_porCnt == POR_LAST) begin
                    w_nextState = ST_HALT;
                end
            end
            ST_HALT: begin
                if (i_run_req) begin
                    w_nextState = ST_RUN;
                end else if (w_stepPulse) begin
                    w_nextState = ST_STEP;
                end
            end
            ST_STEP: begin
                w_cpuCe     = 1'b1;
                w_nextState = ST_HALT;
            end
            ST_RUN: begin
                w_cpuCe = i_run_req && !w_bpMatch;
                if (w_bpMatch) begin
                    w_nextState = ST_HALT;
                    w_setBpHit  = 1'b1;
                end else if (!i_run_req) begin
                    w_nextState = ST_HALT;
                end
            end
            default: begin
                w_nextState = ST_POR;
            end
        endcase
        if (i_rst_req) begin
            w_nextState = ST_POR;
            w_setBpHit  = 1'b0;
        end
    end

    // State register plus the registered outputs that follow it. The POR
    // counter restarts on a soft reset and idles at zero outside POR. The
    // breakpoint arm and hit flags are both dropped whenever HALT is left,
    // and the arm is set by every cycle spent in RUN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_POR;
            r_porCnt    <= '0;
            r_cpuRst    <= 1'b1;
            r_halted    <= 1'b0;
            r_bpHit     <= 1'b0;
            r_bpArmed   <= 1'b0;
            r_insnCount <= '0;
        end else begin
            r_state  <= w_nextState;
            r_cpuRst <= (w_nextState == ST_POR);
            r_halted <= (w_nextState == ST_HALT);

            if (i_rst_req || (r_state != ST_POR)) begin
                r_porCnt <= '0;
            end else begin
                r_porCnt <= r_porCnt + POR_W'(1);
            end

            if ((r_state == ST_HALT) && (w_nextState != ST_HALT)) begin
                r_bpArmed <= 1'b0;
                r_bpHit   <= 1'b0;
            end else begin
                if (r_state == ST_RUN) begin
                    r_bpArmed <= 1'b1;
                end
                if (w_setBpHit) begin
                    r_bpHit <= 1'b1;
                end
            end

            if (r_state == ST_POR) begin
                r_insnCount <= '0;
            end else if (w_cpuCe && !r_cpuRst) begin
                r_insnCount <= r_insnCount + 16'd1;
            end
        end
    end

    assign o_cpu_rst    = r_cpuRst;
    assign o_cpu_ce     = w_cpuCe;
    assign o_halted     = r_halted;
    assign o_bp_hit     = r_bpHit;
    assign o_insn_count = r_insnCount;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// tb_hack_run_ctrl
// Self-checking bench for hack_run_ctrl. A behavioural model of the
// controller and of a CPU running straight-line code (pc + 1 per enabled
// edge, pc = 0 on an enabled edge under reset) supplies i_pc and every
// expected value. Scenario tasks are called in sequence from one initial
// block, followed by a randomized run checked cycle by cycle.

module tb_hack_run_ctrl;

    localparam int PC_WIDTH   = 15;
    localparam int POR_CYCLES = 16;
    localparam int DEB        = 4;

    localparam int M_POR  = 0;
    localparam int M_HALT = 1;
    localparam int M_STEP = 2;
    localparam int M_RUN  = 3;

    logic                clk = 1'b0;
    logic                rstN;
    logic                runReq;
    logic                rstReq;
    logic                stepBtn;
    logic                bpEn;
    logic [PC_WIDTH-1:0] bpAddr;
    logic [PC_WIDTH-1:0] mPc;
    logic                cpuRst;
    logic                cpuCe;
    logic                halted;
    logic                bpHit;
    logic [15:0]         insnCount;

    int          mMode;
    int          mPorEdges;
    bit          mArmed;
    bit          mBpHit;
    logic [15:0] mCount;
    bit          mLevel;
    bit          mLevelPrev;
    bit          mH1;
    bit          mH2;
    int          mDiffRun;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hack_run_ctrl #(
        .PC_WIDTH        (PC_WIDTH),
        .POR_CYCLES      (POR_CYCLES),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_run_req    (runReq),
        .i_rst_req    (rstReq),
        .i_step_btn   (stepBtn),
        .i_bp_en      (bpEn),
        .i_bp_addr    (bpAddr),
        .i_pc         (mPc),
        .o_cpu_rst    (cpuRst),
        .o_cpu_ce     (cpuCe),
        .o_halted     (halted),
        .o_bp_hit     (bpHit),
        .o_insn_count (insnCount)
    );

    // Expected clock enable for the current mode and inputs.
    function automatic bit modelCe();
        case (mMode)
            M_POR:   return 1'b1;
            M_STEP:  return 1'b1;
            M_RUN:   return runReq && !(bpEn && mArmed && (mPc == bpAddr));
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        mMode      = M_POR;
        mPorEdges  = 0;
        mArmed     = 1'b0;
        mBpHit     = 1'b0;
        mCount     = 16'd0;
        mLevel     = 1'b0;
        mLevelPrev = 1'b0;
        mH1        = 1'b0;
        mH2        = 1'b0;
        mDiffRun   = 0;
    endtask

    // Advance one clock edge; the model applies the rules to the inputs that
    // were present before the edge, then the CPU model moves its pc.
    task automatic tick();
        bit ce;
        bit pulse;
        bit match;
        bit synced;
        int oldMode;
        @(posedge clk);
        #1;
        ce      = modelCe();
        pulse   = mLevel && !mLevelPrev;
        match   = bpEn && mArmed && (mPc == bpAddr);
        oldMode = mMode;
        if (mMode == M_POR) mCount = 16'd0;
        else if (ce) mCount = mCount + 16'd1;
        if (ce) mPc = (mMode == M_POR) ? '0 : mPc + 1'b1;
        if (rstReq) begin
            mMode     = M_POR;
            mPorEdges = 0;
        end else begin
            case (mMode)
                M_POR: begin
                    mPorEdges++;
                    if (mPorEdges == POR_CYCLES) mMode = M_HALT;
                end
                M_HALT: begin
                    if (runReq) mMode = M_RUN;
                    else if (pulse) mMode = M_STEP;
                end
                M_STEP: mMode = M_HALT;
                default: begin
                    if (match) begin
                        mMode  = M_HALT;
                        mBpHit = 1'b1;
                    end else if (!runReq) begin
                        mMode = M_HALT;
                    end
                end
            endcase
        end
        if (oldMode == M_RUN) mArmed = 1'b1;
        if (oldMode == M_HALT && mMode != M_HALT) begin
            mArmed = 1'b0;
            mBpHit = 1'b0;
        end
        synced     = mH2;
        mH2        = mH1;
        mH1        = stepBtn;
        mLevelPrev = mLevel;
        if (synced != mLevel) begin
            mDiffRun++;
            if (mDiffRun == DEB) begin
                mLevel   = !mLevel;
                mDiffRun = 0;
            end
        end else begin
            mDiffRun = 0;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b1; runReq = 1'b0; rstReq = 1'b0; stepBtn = 1'b0;
        bpEn = 1'b0; bpAddr = '0; mPc = '0;
        #1 rstN = 1'b0;
        modelReset();
        #1;
        compared++;
        if ({cpuRst, cpuCe, halted, bpHit} !== 4'b1100) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got rst/ce/halt/hit=%b expected 1100", {cpuRst, cpuCe, halted, bpHit});
        end
        compared++;
        if (insnCount !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_count: got %0d expected 0", insnCount);
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int e = 1; e <= POR_CYCLES; e++) begin
            tick();
            if (e < POR_CYCLES) begin
                compared++;
                if (cpuRst !== 1'b1 || halted !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL por_hold edge %0d: got rst=%b halt=%b expected rst=1 halt=0", e, cpuRst, halted);
                end
            end
        end
        compared++;
        if ({cpuRst, halted, cpuCe} !== 3'b010 || insnCount !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL por_exit: got rst/halt/ce=%b count=%0d expected 010 count=0", {cpuRst, halted, cpuCe}, insnCount);
        end
    endtask

    task automatic test_single_step();
        int segVal[6] = '{1, 0, 1, 0, 1, 0};
        int segLen[6] = '{10, 3, 10, 12, 2, 12};
        int ceCycles  = 0;
        int firstCe   = -1;
        int t         = 0;
        logic [15:0] startCount = mCount;
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < segLen[s]; c++) begin
                stepBtn = segVal[s][0];
                #1;
                compared++;
                if (cpuCe !== modelCe()) begin
                    mismatched++;
                    $display("[TB] FAIL step_ce t=%0d: got %b expected %b", t, cpuCe, modelCe());
                end
                tick();
                t++;
                if (cpuCe === 1'b1) begin
                    ceCycles++;
                    if (firstCe < 0) firstCe = t;
                end
            end
        end
        compared++;
        if (ceCycles != 1) begin
            mismatched++;
            $display("[TB] FAIL step_ce_cycles: got %0d expected 1", ceCycles);
        end
        compared++;
        if (firstCe + 1 < 4 || firstCe + 1 > DEB + 4) begin
            mismatched++;
            $display("[TB] FAIL step_latency: got edge %0d expected 4..%0d", firstCe + 1, DEB + 4);
        end
        compared++;
        if (insnCount !== startCount + 16'd1 || insnCount !== mCount) begin
            mismatched++;
            $display("[TB] FAIL step_count: got %0d expected %0d", insnCount, startCount + 16'd1);
        end
        compared++;
        if (halted !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL step_halted: got %b expected 1", halted);
        end
    endtask

    task automatic test_run_halt();
        int extraCe = 0;
        int delta;
        logic [15:0] startCount = mCount;
        runReq = 1'b1;
        for (int i = 0; i < 100; i++) begin
            stepBtn = (i >= 20 && i < 30);
            #1;
            compared++;
            if (cpuCe !== modelCe()) begin
                mismatched++;
                $display("[TB] FAIL run_ce cycle %0d: got %b expected %b", i, cpuCe, modelCe());
            end
            tick();
        end
        runReq = 1'b0;
        #1;
        compared++;
        if (cpuCe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL run_stop_ce: got %b expected 0", cpuCe);
        end
        tick();
        compared++;
        if (halted !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL run_halted: got %b expected 1", halted);
        end
        delta = int'(insnCount - startCount);
        compared++;
        if (insnCount !== mCount || delta < 99 || delta > 101) begin
            mismatched++;
            $display("[TB] FAIL run_count: got %0d expected %0d", insnCount, mCount);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpuCe === 1'b1) extraCe++;
        end
        compared++;
        if (extraCe != 0) begin
            mismatched++;
            $display("[TB] FAIL run_step_ignored: got %0d enabled cycles expected 0", extraCe);
        end
    endtask

    task automatic test_breakpoint();
        bit stopped = 1'b0;
        rstReq = 1'b1;
        tick();
        rstReq = 1'b0;
        repeat (POR_CYCLES) tick();
        bpEn   = 1'b1;
        bpAddr = 15'h0005;
        runReq = 1'b1;
        tick();
        for (int i = 0; i < 40 && !stopped; i++) begin
            tick();
            if (halted === 1'b1) stopped = 1'b1;
        end
        runReq = 1'b0;
        compared++;
        if (!stopped) begin
            mismatched++;
            $display("[TB] FAIL bp_stop: got no halt within 40 cycles expected halt");
        end
        #1;
        compared++;
        if (insnCount !== 16'd5 || bpHit !== 1'b1 || cpuCe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_state: got count=%0d hit=%b ce=%b expected count=5 hit=1 ce=0", insnCount, bpHit, cpuCe);
        end
        repeat (3) tick();
        compared++;
        if (insnCount !== 16'd5 || bpHit !== 1'b1 || halted !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_hold: got count=%0d hit=%b halt=%b expected 5 1 1", insnCount, bpHit, halted);
        end
        runReq = 1'b1;
        tick();
        compared++;
        if (bpHit !== 1'b0 || cpuCe !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_resume: got hit=%b ce=%b expected hit=0 ce=1", bpHit, cpuCe);
        end
        tick();
        compared++;
        if (insnCount !== 16'd6 || insnCount !== mCount) begin
            mismatched++;
            $display("[TB] FAIL bp_resume_count: got %0d expected 6", insnCount);
        end
        runReq = 1'b0;
        bpEn   = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_soft_reset();
        runReq = 1'b1;
        repeat (10) tick();
        rstReq = 1'b1;
        runReq = 1'b0;
        tick();
        rstReq = 1'b0;
        compared++;
        if (cpuRst !== 1'b1 || halted !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL soft_rst_enter: got rst=%b halt=%b expected 1 0", cpuRst, halted);
        end
        for (int e = 1; e <= POR_CYCLES; e++) begin
            tick();
            if (e < POR_CYCLES) begin
                compared++;
                if (cpuRst !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL soft_rst_hold edge %0d: got %b expected 1", e, cpuRst);
                end
            end
        end
        compared++;
        if ({cpuRst, halted} !== 2'b01 || insnCount !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL soft_rst_exit: got rst/halt=%b count=%0d expected 01 count=0", {cpuRst, halted}, insnCount);
        end
    endtask

    task automatic test_count_wrap();
        bpEn   = 1'b0;
        runReq = 1'b1;
        tick();
        for (int i = 1; i <= 65537; i++) begin
            tick();
            if (i == 65536) begin
                compared++;
                if (insnCount !== 16'h0000 || insnCount !== mCount) begin
                    mismatched++;
                    $display("[TB] FAIL wrap_zero: got %h expected 0000", insnCount);
                end
            end
        end
        compared++;
        if (insnCount !== 16'h0001 || insnCount !== mCount) begin
            mismatched++;
            $display("[TB] FAIL wrap_one: got %h expected 0001", insnCount);
        end
        runReq = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bit inStep = 1'b0;
        stepBtn = 1'b1;
        for (int i = 0; i < 30 && !inStep; i++) begin
            tick();
            if (cpuCe === 1'b1) inStep = 1'b1;
        end
        stepBtn = 1'b0;
        compared++;
        if (!inStep || mMode != M_STEP) begin
            mismatched++;
            $display("[TB] FAIL async_reach_step: got ce_seen=%b expected STEP within 30 cycles", inStep);
        end
        #2 rstN = 1'b0;
        modelReset();
        #1;
        compared++;
        if ({cpuCe, cpuRst, halted} !== 3'b110 || insnCount !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got ce/rst/halt=%b count=%0d expected 110 count=0", {cpuCe, cpuRst, halted}, insnCount);
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (POR_CYCLES) tick();
        compared++;
        if (halted !== 1'b1 || cpuRst !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_recover: got halt=%b rst=%b expected 1 0", halted, cpuRst);
        end
    endtask

    task automatic test_random();
        int btnLeft = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) runReq = ~runReq;
            rstReq = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 29) == 0) begin
                bpEn   = $urandom_range(0, 1);
                bpAddr = mPc + PC_WIDTH'($urandom_range(0, 6));
            end
            if (btnLeft == 0) begin
                stepBtn = $urandom_range(0, 1);
                btnLeft = $urandom_range(1, 12);
            end
            btnLeft--;
            #1;
            compared++;
            if (cpuCe !== modelCe()) begin
                mismatched++;
                $display("[TB] FAIL rand_ce cycle %0d: got %b expected %b", i, cpuCe, modelCe());
            end
            tick();
            compared++;
            if (cpuRst !== (mMode == M_POR) || halted !== (mMode == M_HALT)) begin
                mismatched++;
                $display("[TB] FAIL rand_state cycle %0d: got rst=%b halt=%b expected rst=%b halt=%b", i, cpuRst, halted, mMode == M_POR, mMode == M_HALT);
            end
            compared++;
            if (bpHit !== mBpHit) begin
                mismatched++;
                $display("[TB] FAIL rand_bp_hit cycle %0d: got %b expected %b", i, bpHit, mBpHit);
            end
            compared++;
            if (insnCount !== mCount) begin
                mismatched++;
                $display("[TB] FAIL rand_count cycle %0d: got %0d expected %0d", i, insnCount, mCount);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_run_halt();
        test_breakpoint();
        test_soft_reset();
        test_count_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hack_run_ctrl.md
# hack_run_ctrl

Run/halt/single-step controller for the HACK CPU. Generates the CPU's clock enable and reset from one free-running clock, so the CPU and its ROM/RAM can be halted, single-stepped from a debounced button, and stopped on a program-counter breakpoint. Sits between the board inputs (reset button, run switch, step button) and the CPU's reset pin and datapath clock enable. It also keeps an executed-instruction counter for the display.

## Interface
- `PC_WIDTH`, 15: width of the program counter and breakpoint address.
- `POR_CYCLES`, 16: number of cycles `cpu_rst` is held after reset or a soft-reset request.
- `DEBOUNCE_CYCLES`, 16000: number of consecutive stable cycles required to accept a step-button level (1 ms at 16 MHz).
- `CLK` in 1: 16 MHz system clock. All state changes on its rising edge.
- `RST` in 1: reset. Asynchronous, active-low.
- `run_req` in 1: level. 1 requests free run, 0 requests halt. Already synchronous to `CLK`.
- `rst_req` in 1: single-cycle soft-reset request. Re-enters POR.
- `step_btn` in 1: raw, asynchronous, active-high step button.
- `bp_en` in 1: enables the breakpoint.
- `bp_addr` in PC_WIDTH: breakpoint instruction address.
- `pc` in PC_WIDTH: current CPU program counter.
- `cpu_rst` out 1: reset to the CPU.
- `cpu_ce` out 1: CPU clock enable. Registers update only on edges where this is 1.
- `halted` out 1: 1 while in HALT.
- `bp_hit` out 1: sticky; set when the breakpoint stops RUN.
- `insn_count` out 16: count of executed instructions.

## Operation
- States are POR, HALT, STEP and RUN. Reset puts the block in POR with: por counter 0, `cpu_rst`=1, `cpu_ce`=1, `halted`=0, `bp_hit`=0, `insn_count`=0, `bp_armed`=0, debouncer level 0.
- **POR**
  - `cpu_rst`=1 and `cpu_ce`=1, so the CPU's synchronous reset takes effect.
  - `insn_count` is held at 0.
  - After POR_CYCLES cycles, go to HALT.
- **HALT**
  - `cpu_ce`=0, `halted`=1.
  - If `run_req`=1, go to RUN. `run_req` has priority over a step pulse in the same cycle.
  - Else, on a step pulse, go to STEP.
  - Leaving HALT clears `bp_armed` and `bp_hit`.
- **STEP**
  - `cpu_ce`=1 for exactly one cycle, then return to HALT.
  - Breakpoints are ignored in STEP.
- **RUN**
  - `cpu_ce` = NOT(`bp_en` AND `bp_armed` AND `pc`==`bp_addr`).
  - `bp_armed` is set after the first cycle in RUN. This lets a resume at the breakpoint address execute that instruction.
  - On a breakpoint match, `cpu_ce`=0 in the same cycle, `bp_hit` is set, and the next state is HALT.
  - If `run_req`=0, `cpu_ce`=0 in that cycle and the next state is HALT.
- **Soft reset:** `rst_req`=1 in any state goes to POR on the next edge and restarts the por counter. It has priority over every other transition.
- **Step debouncer**
  - `step_btn` passes through a 2-flop synchronizer.
  - A counter loads 0 whenever the synchronized input equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES−1, the debounced level toggles.
  - Each 0→1 transition of the debounced level is one step pulse.
  - A step pulse outside HALT is discarded; it is not queued.
- **Instruction count:** `insn_count` increments on every edge where `cpu_ce`=1 and `cpu_rst`=0. It wraps 0xFFFF→0x0000 and is cleared only in POR.

## Timing
- `cpu_ce` is combinational from state, `pc`, `bp_en`, `bp_addr` and `bp_armed`. All other outputs are registered.
- Deassertion of `RST` → `cpu_rst` falls POR_CYCLES edges later. `halted` rises on the same edge.
- HALT with `run_req` rising → RUN on the next edge. The first enabled CPU edge is the following one.
- `run_req` falling in RUN → `cpu_ce`=0 immediately. `halted`=1 after the next edge.
- A step press stable for DEBOUNCE_CYCLES → exactly one cycle of `cpu_ce`=1, 4 to DEBOUNCE_CYCLES+4 edges after the press. The CPU's `pc` advances by one instruction.
- Breakpoint: the instruction at `bp_addr` is never executed in RUN before the stop. `pc` stays equal to `bp_addr` while halted.
- Assertion of `RST` mid-RUN or mid-STEP → all outputs take their reset values immediately (asynchronous).

## Test plan
- **Reset:** `RST` low then high → `cpu_rst`=1 for 16 edges, then `halted`=1, `cpu_ce`=0, `insn_count`=0.
- **Single step:** with DEBOUNCE_CYCLES=4, in HALT, step held 10 cycles then 3-cycle glitch low/high → exactly one `cpu_ce` cycle, `insn_count`=1. A 2-cycle bounce produces no extra step.
- **Run/halt:** `run_req`=1 for 100 cycles then 0 → `insn_count`=100 (±1 per spec edges), `halted`=1. A step pulse asserted during RUN is ignored.
- **Breakpoint stop and resume:** `bp_en`=1, `bp_addr`=0x0005, run from PC 0 with linear code → stop with `pc`=0x0005, `bp_hit`=1, `insn_count`=5. Re-asserting `run_req` executes 0x0005 and clears `bp_hit`.
- **Soft reset and count wrap:** `rst_req` pulse mid-RUN → POR for 16 cycles, then HALT with `insn_count`=0. Force 65537 enabled cycles → `insn_count`=0x0001.
- **Async reset mid-step:** drop `RST` during STEP → `cpu_ce`=1, `cpu_rst`=1, `halted`=0 without waiting for a clock edge.
